kernel_bias_loader: RTL and testbench

Upstream write-side stage for the kernel/bias BRAM bank group: accepts a valid/ready word stream from the PS-side DMA and writes it bank-major into the `KERNEL_BRAM_NUM` kernel/bias BRAMs through their port A (enable, write-enable, address, data, reset). It clears the bank output latches before each load and pulses `o_done` when every bank holds `i_word_count` words. The read side (port B, data-point addressing) is outside this block.

---
 rtl/cnn_kernel_pkg.sv | 26 ++
 rtl/kb_addr_counter.sv | 84 ++++++++
 rtl/kernel_bias_loader.sv | 165 ++++++++++++++++
 tb/tb_kernel_bias_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_kernel_pkg.sv
// -----------------------------------------------------------------------------
// cnn_kernel_pkg
// Shared definitions for the kernel/bias BRAM bank group: default geometry,
// the packed bytes-per-word constant (also used by the read-side data-point
// divide), the loader FSM state type and a small width helper.
// -----------------------------------------------------------------------------
package cnn_kernel_pkg;

    localparam int KB_DATA_WIDTH      = 32;
    localparam int KB_KERNEL_BRAM_NUM = 4;
    localparam int KB_ADDRESS_WIDTH   = 10;
    localparam int BYTES_PER_WORD     = 4;

    typedef enum logic [1:0] {
        KB_IDLE  = 2'd0,
        KB_CLEAR = 2'd1,
        KB_LOAD  = 2'd2,
        KB_DONE  = 2'd3
    } kb_load_state_t;

    // Counter width for 'value' states, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/kb_addr_counter.sv
// -----------------------------------------------------------------------------
// kb_addr_counter
// Bank-major write position counter. On i_load it latches the words-per-bank
// limit (saturated to a full bank) and clears both counters; each i_step
// advances the address, wrapping to 0 at limit-1 and moving to the next bank.
//
// Ports:
//   i_clock, i_reset  clock, asynchronous active-low reset
//   i_load            latch limit from i_word_count, clear counters
//   i_word_count      requested words per bank
//   i_step            advance by one word
//   o_addr            current address inside the bank
//   o_bank            current bank index
//   o_zero            latched limit is zero (nothing to load)
//   o_last            current position is the final word of the final bank
// -----------------------------------------------------------------------------
module kb_addr_counter
    import cnn_kernel_pkg::*;
#(
    parameter int ADDRESS_WIDTH = KB_ADDRESS_WIDTH,
    parameter int BANK_NUM      = KB_KERNEL_BRAM_NUM,
    parameter int COUNT_WIDTH   = 16,
    localparam int CNT_WIDTH    = ADDRESS_WIDTH + 1,
    localparam int BANK_WIDTH   = clog2_min1(BANK_NUM)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_load,
    input  logic [COUNT_WIDTH-1:0]   i_word_count,
    input  logic                     i_step,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic [BANK_WIDTH-1:0]    o_bank,
    output logic                     o_zero,
    output logic                     o_last
);

    // One extra bit so a completely full bank (2^ADDRESS_WIDTH) is representable.
    localparam logic [CNT_WIDTH-1:0]  FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [BANK_WIDTH-1:0] LAST_BANK  = BANK_WIDTH'(BANK_NUM - 1);

    logic [CNT_WIDTH-1:0]  limit_q;
    logic [CNT_WIDTH-1:0]  addr_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [CNT_WIDTH-1:0]  sat_count;
    logic                  addr_at_end;

    // Any bit at or above ADDRESS_WIDTH means the request is at least a full bank.
    always_comb begin
        if ((i_word_count >> ADDRESS_WIDTH) != '0) begin
            sat_count = FULL_COUNT;
        end else begin
            sat_count = CNT_WIDTH'(i_word_count);
        end
    end

    assign addr_at_end = (addr_q + CNT_WIDTH'(1)) == limit_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            limit_q <= '0;
            addr_q  <= '0;
            bank_q  <= '0;
        end else if (i_load) begin
            limit_q <= sat_count;
            addr_q  <= '0;
            bank_q  <= '0;
        end else if (i_step) begin
            if (addr_at_end) begin
                addr_q <= '0;
                bank_q <= bank_q + 1'b1;
            end else begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign o_addr = addr_q[ADDRESS_WIDTH-1:0];
    assign o_bank = bank_q;
    assign o_zero = (limit_q == '0);
    assign o_last = addr_at_end && (bank_q == LAST_BANK);

endmodule

// File: rtl/kernel_bias_loader.sv
// -----------------------------------------------------------------------------
// kernel_bias_loader
// Write-side stage of the kernel/bias BRAM bank group. Accepts a valid/ready
// word stream and writes it bank-major through port A of KERNEL_BRAM_NUM BRAMs,
// first holding the bank output-latch resets for CLEAR_CYCLES cycles, then
// pulsing o_done once every bank holds the requested word count.
//
// Ports:
//   i_clock, i_reset     clock, asynchronous active-low reset
//   i_start              start pulse, honoured only when idle
//   i_word_count         words per bank, latched (saturated) on start
//   i_s_valid, i_s_data  input word stream
//   o_s_ready            a word is accepted this cycle when valid is high
//   o_ps_enable[b]       port-A enable, one-cycle strobe per written word
//   o_wenable[b]         port-A write enable, same strobe
//   o_waddress[b]        port-A address, held between writes
//   o_bram_data[b]       port-A write data, held between writes
//   o_bram_rst           port-A reset, one bit per bank
//   o_busy               load in progress
//   o_done               one-cycle completion pulse
// -----------------------------------------------------------------------------
module kernel_bias_loader
    import cnn_kernel_pkg::*;
#(
    parameter int DATA_WIDTH                     = KB_DATA_WIDTH,
    parameter int KERNEL_BRAM_NUM                = KB_KERNEL_BRAM_NUM,
    parameter int KERNEL_BIAS_BRAM_ADDRESS_WIDTH = KB_ADDRESS_WIDTH,
    parameter int COUNT_WIDTH                    = 16,
    parameter int CLEAR_CYCLES                   = 4
) (
    input  logic                                      i_clock,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic [COUNT_WIDTH-1:0]                    i_word_count,
    input  logic                                      i_s_valid,
    input  logic [DATA_WIDTH-1:0]                     i_s_data,
    output logic                                      o_s_ready,
    output logic                                      o_ps_enable [0:KERNEL_BRAM_NUM-1],
    output logic                                      o_wenable   [0:KERNEL_BRAM_NUM-1],
    output logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] o_waddress  [0:KERNEL_BRAM_NUM-1],
    output logic [DATA_WIDTH-1:0]                     o_bram_data [0:KERNEL_BRAM_NUM-1],
    output logic [KERNEL_BRAM_NUM-1:0]                o_bram_rst,
    output logic                                      o_busy,
    output logic                                      o_done
);

    localparam int AW         = KERNEL_BIAS_BRAM_ADDRESS_WIDTH;
    localparam int BANK_WIDTH = clog2_min1(KERNEL_BRAM_NUM);
    localparam int CLR_WIDTH  = clog2_min1(CLEAR_CYCLES);
    localparam logic [CLR_WIDTH-1:0] CLR_LAST = CLR_WIDTH'(CLEAR_CYCLES - 1);

    kb_load_state_t        state_q;
    logic [CLR_WIDTH-1:0]  clr_cnt_q;
    logic                  start_accept;
    logic                  handshake;
    logic [AW-1:0]         addr_cnt;
    logic [BANK_WIDTH-1:0] bank_cnt;
    logic                  count_zero;
    logic                  last_word;

    assign start_accept = (state_q == KB_IDLE) && i_start;
    // o_s_ready is registered high exactly while in LOAD, so this is the
    // stream handshake and never consumes a word in any other state.
    assign handshake    = i_s_valid && o_s_ready;

    kb_addr_counter #(
        .ADDRESS_WIDTH (AW),
        .BANK_NUM      (KERNEL_BRAM_NUM),
        .COUNT_WIDTH   (COUNT_WIDTH)
    ) u_addr_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (start_accept),
        .i_word_count (i_word_count),
        .i_step       (handshake),
        .o_addr       (addr_cnt),
        .o_bank       (bank_cnt),
        .o_zero       (count_zero),
        .o_last       (last_word)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= KB_IDLE;
            clr_cnt_q  <= '0;
            o_s_ready  <= 1'b0;
            o_bram_rst <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            // NOTE: the per-bank address/data registers are plain output
            // registers, not RAM, so they take the reset like everything else.
            for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
                o_ps_enable[b] <= 1'b0;
                o_wenable[b]   <= 1'b0;
                o_waddress[b]  <= '0;
                o_bram_data[b] <= '0;
            end
        end else begin
            // NOTE: strobes default low every cycle and are raised only by the
            // branch that needs them, which makes them single-cycle pulses.
            for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
                o_ps_enable[b] <= 1'b0;
                o_wenable[b]   <= 1'b0;
            end
            o_done <= 1'b0;

            case (state_q)
                KB_IDLE: begin
                    if (i_start) begin
                        state_q    <= KB_CLEAR;
                        clr_cnt_q  <= '0;
                        o_bram_rst <= '1;
                        o_busy     <= 1'b1;
                    end
                end

                KB_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        o_bram_rst <= '0;
                        if (count_zero) begin
                            state_q <= KB_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            state_q   <= KB_LOAD;
                            o_s_ready <= 1'b1;
                        end
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end

                KB_LOAD: begin
                    if (handshake) begin
                        // Only the addressed bank is strobed; the other banks
                        // keep their last address and data.
                        for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
                            if (bank_cnt == BANK_WIDTH'(b)) begin
                                o_ps_enable[b] <= 1'b1;
                                o_wenable[b]   <= 1'b1;
                                o_waddress[b]  <= addr_cnt;
                                o_bram_data[b] <= i_s_data;
                            end
                        end
                        if (last_word) begin
                            state_q   <= KB_DONE;
                            o_s_ready <= 1'b0;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                        end
                    end
                end

                KB_DONE: begin
                    state_q <= KB_IDLE;
                end

                default: begin
                    state_q <= KB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_bias_loader.sv
// -----------------------------------------------------------------------------
// tb_kernel_bias_loader
// Self-checking bench for kernel_bias_loader. Two instances share the stream:
// u_dut uses the default geometry, u_sat a 2-bit address to exercise
// saturation at a full bank. Windows are numbered from the cycle i_start is
// driven (window 0); every expectation is derived from the vector record.
// -----------------------------------------------------------------------------
module tb_kernel_bias_loader;
    import cnn_kernel_pkg::*;

    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int AW  = 10;
    localparam int SAW = 2;
    localparam int CW  = 16;
    localparam int CLR = 4;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          start_def;
    logic          start_sat;
    logic [CW-1:0] i_word_count;
    logic          i_s_valid;
    logic [DW-1:0] i_s_data;

    logic           d_ready, d_busy, d_done;
    logic           d_en   [0:NB-1];
    logic           d_we   [0:NB-1];
    logic [AW-1:0]  d_addr [0:NB-1];
    logic [DW-1:0]  d_data [0:NB-1];
    logic [NB-1:0]  d_rst;

    logic           s_ready, s_busy, s_done;
    logic           s_en   [0:NB-1];
    logic           s_we   [0:NB-1];
    logic [SAW-1:0] s_addr [0:NB-1];
    logic [DW-1:0]  s_data [0:NB-1];
    logic [NB-1:0]  s_rst;

    always #5 i_clock = ~i_clock;

    kernel_bias_loader u_dut (
        .i_clock (i_clock), .i_reset (i_reset), .i_start (start_def),
        .i_word_count (i_word_count), .i_s_valid (i_s_valid), .i_s_data (i_s_data),
        .o_s_ready (d_ready), .o_ps_enable (d_en), .o_wenable (d_we),
        .o_waddress (d_addr), .o_bram_data (d_data), .o_bram_rst (d_rst),
        .o_busy (d_busy), .o_done (d_done)
    );

    kernel_bias_loader #(.KERNEL_BIAS_BRAM_ADDRESS_WIDTH(SAW)) u_sat (
        .i_clock (i_clock), .i_reset (i_reset), .i_start (start_sat),
        .i_word_count (i_word_count), .i_s_valid (i_s_valid), .i_s_data (i_s_data),
        .o_s_ready (s_ready), .o_ps_enable (s_en), .o_wenable (s_we),
        .o_waddress (s_addr), .o_bram_data (s_data), .o_bram_rst (s_rst),
        .o_busy (s_busy), .o_done (s_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Observed outputs of the selected instance (0 = u_dut, 1 = u_sat).
    logic          obs_ready, obs_busy, obs_done;
    logic [NB-1:0] obs_rst;
    logic          obs_en   [NB];
    logic          obs_we   [NB];
    logic [AW-1:0] obs_addr [NB];
    logic [DW-1:0] obs_data [NB];

    task automatic sample(input bit sel);
        obs_ready = sel ? s_ready : d_ready;
        obs_busy  = sel ? s_busy  : d_busy;
        obs_done  = sel ? s_done  : d_done;
        obs_rst   = sel ? s_rst   : d_rst;
        for (int b = 0; b < NB; b++) begin
            obs_en[b]   = sel ? s_en[b] : d_en[b];
            obs_we[b]   = sel ? s_we[b] : d_we[b];
            obs_addr[b] = sel ? AW'(s_addr[b]) : d_addr[b];
            obs_data[b] = sel ? s_data[b] : d_data[b];
        end
    endtask

    task automatic check_all_zero(input string name, input bit sel);
        logic en_or, we_or;
        logic [AW-1:0] addr_or;
        logic [DW-1:0] data_or;
        sample(sel);
        en_or = 1'b0; we_or = 1'b0; addr_or = '0; data_or = '0;
        for (int b = 0; b < NB; b++) begin
            en_or   = en_or | obs_en[b];
            we_or   = we_or | obs_we[b];
            addr_or = addr_or | obs_addr[b];
            data_or = data_or | obs_data[b];
        end
        check({name, "_ready"}, obs_ready, 0);
        check({name, "_busy"},  obs_busy, 0);
        check({name, "_done"},  obs_done, 0);
        check({name, "_rst"},   obs_rst, 0);
        check({name, "_en"},    en_or, 0);
        check({name, "_we"},    we_or, 0);
        check({name, "_addr"},  addr_or, 0);
        check({name, "_data"},  data_or, 0);
    endtask

    typedef struct {
        string         name;
        bit            sel;            // 1: run on u_sat
        int            count;          // i_word_count at start
        bit            gap;            // valid toggles 1,0,1,0 during LOAD
        bit            valid_in_clear; // valid held high during CLEAR
        bit            start_in_load;  // extra start pulse in LOAD
        logic [DW-1:0] base;           // first stream word
        int            exp_eff;        // expected words per bank
        int            exp_done_w;     // expected window of o_done
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int  k = 0;
        int  total;
        int  last_hs_w;
        int  x;
        int  hs_k = 0;
        bit  hs;
        bit  exp_en;
        int  writes = 0, done_cnt = 0, done_seen = -1;
        int  err_rst = 0, err_busy = 0, err_ready = 0, err_wr = 0, err_hold = 0;
        logic [AW-1:0] prev_addr [NB];
        logic [DW-1:0] prev_data [NB];

        total     = NB * v.exp_eff;
        last_hs_w = CLR + 1 + (total - 1) * (v.gap ? 2 : 1);
        sample(v.sel);
        for (int b = 0; b < NB; b++) begin
            prev_addr[b] = obs_addr[b];
            prev_data[b] = obs_data[b];
        end

        for (int w = 0; w <= v.exp_done_w + 2; w++) begin
            // Drive window w.
            i_word_count = (w == 0) ? CW'(v.count) : CW'(7);
            start_def    = !v.sel && ((w == 0) || (v.start_in_load && w == 6));
            start_sat    = v.sel && (w == 0);
            if (w > CLR)
                i_s_valid = (k < total) && (!v.gap || ((w - CLR - 1) % 2 == 0));
            else
                i_s_valid = v.valid_in_clear && (w >= 1);
            hs   = (total > 0) && (w > CLR) && (w <= last_hs_w) && i_s_valid;
            hs_k = k;
            i_s_data = hs ? (v.base + DW'(k)) : (32'hDEAD_0000 + DW'(w));
            if (hs) k++;
            step();
            sample(v.sel);

            // Check window w+1.
            x = w + 1;
            if (obs_rst !== ((x >= 1 && x <= CLR) ? {NB{1'b1}} : {NB{1'b0}})) err_rst++;
            if (obs_busy !== (x >= 1 && x < v.exp_done_w)) err_busy++;
            if (obs_ready !== ((total > 0) && (x > CLR) && (x <= last_hs_w))) err_ready++;
            if (obs_done) begin
                done_cnt++;
                if (done_seen < 0) done_seen = x;
            end
            for (int b = 0; b < NB; b++) begin
                exp_en = 1'b0;
                if (hs) exp_en = ((hs_k / v.exp_eff) == b);
                if (obs_en[b] !== exp_en || obs_we[b] !== exp_en) err_wr++;
                if (obs_en[b] === 1'b1 && obs_we[b] === 1'b1) writes++;
                if (exp_en) begin
                    if (obs_addr[b] !== AW'(hs_k % v.exp_eff)) err_wr++;
                    if (obs_data[b] !== (v.base + DW'(hs_k))) err_wr++;
                end else if (obs_addr[b] !== prev_addr[b] || obs_data[b] !== prev_data[b]) begin
                    err_hold++;
                end
                prev_addr[b] = obs_addr[b];
                prev_data[b] = obs_data[b];
            end
        end
        start_def = 1'b0;
        start_sat = 1'b0;
        i_s_valid = 1'b0;

        check({v.name, "_rst_errs"},   err_rst, 0);
        check({v.name, "_busy_errs"},  err_busy, 0);
        check({v.name, "_ready_errs"}, err_ready, 0);
        check({v.name, "_write_errs"}, err_wr, 0);
        check({v.name, "_hold_errs"},  err_hold, 0);
        check({v.name, "_writes"},     writes, total);
        check({v.name, "_done_window"}, done_seen, v.exp_done_w);
        check({v.name, "_done_pulses"}, done_cnt, 1);
    endtask

    int wr;
    int done_cnt;
    int busy_cnt;

    initial begin
        //          name        sel count gap vic sil base          eff  done
        vecs[0] = '{"basic",    0,  3,    0,  0,  0,  32'h0000_0100, 3,    17};
        vecs[1] = '{"backpres", 0,  2,    1,  0,  0,  32'h0000_0200, 2,    20};
        vecs[2] = '{"zero",     0,  0,    0,  0,  0,  32'h0000_0300, 0,    5};
        vecs[3] = '{"sat9",     1,  9,    0,  0,  0,  32'h0000_0400, 4,    21};
        vecs[4] = '{"sat4",     1,  4,    0,  0,  0,  32'h0000_0500, 4,    21};
        vecs[5] = '{"ignored",  0,  1,    0,  1,  1,  32'h0000_0600, 1,    9};
        vecs[6] = '{"sat_def",  0,  1500, 0,  0,  0,  32'h0001_0000, 1024, 4101};

        i_reset = 1'b0;
        start_def = 1'b0; start_sat = 1'b0;
        i_word_count = '0; i_s_valid = 1'b0; i_s_data = '0;
        repeat (2) step();
        check_all_zero("reset_def", 0);
        check_all_zero("reset_sat", 1);
        i_reset = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            repeat (2) step();
        end

        // Reset in the middle of a load: start count 3, stop after 5 writes.
        i_word_count = 16'd3; start_def = 1'b1; i_s_valid = 1'b1; i_s_data = 32'h500;
        step();
        start_def = 1'b0;
        wr = 0;
        for (int t = 0; t < 30 && wr < 5; t++) begin
            i_s_data = 32'h500 + DW'(t);
            step();
            sample(0);
            for (int b = 0; b < NB; b++) if (obs_en[b] === 1'b1) wr++;
        end
        check("midrst_writes_before_reset", wr, 5);
        #2 i_reset = 1'b0;
        #1;
        check_all_zero("midrst", 0);
        i_s_valid = 1'b0;
        step();
        i_reset = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        repeat (10) begin
            step();
            sample(0);
            if (obs_done === 1'b1) done_cnt++;
            if (obs_busy === 1'b1) busy_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_busy", busy_cnt, 0);
        vecs[0].name = "reload";
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
